// File: rtl/johnson_decoder.sv
// Johnson (twisted-ring) code receiver: decodes each sample to index and one-hot,
// checks legality and single-step advance, and tracks lock status and loss count.
module johnson_decoder #(
  parameter int N          = 4,
  parameter int LOCK_COUNT = 4,
  parameter int ALLOW_HOLD = 1,
  localparam int S  = 2 * N,
  localparam int IW = $clog2(S)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  code_in,
  input  logic          code_valid,
  input  logic          err_clr,
  output logic [IW-1:0] index_out,
  output logic [S-1:0]  onehot_out,
  output logic          index_valid,
  output logic          illegal_code,
  output logic          seq_error,
  output logic          locked,
  output logic [7:0]    err_count
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  localparam logic [IW:0] S_W  = (IW+1)'(S);
  localparam logic [3:0]  LC   = 4'(LOCK_COUNT);
  localparam logic        HOLD = (ALLOW_HOLD != 0);

  state_t        state_reg;
  logic [3:0]    streak_reg;
  logic [IW-1:0] prev_reg;
  logic [IW-1:0] index_reg;
  logic [S-1:0]  onehot_reg;
  logic          index_valid_reg;
  logic          illegal_code_reg;
  logic          seq_error_reg;
  logic          locked_reg;
  logic [7:0]    err_count_reg;

  logic [N-2:0]  adj_diff;
  logic [IW:0]   diff_cnt;
  logic [IW:0]   ones_cnt;
  logic [IW:0]   idx_wide;
  logic [IW-1:0] idx;
  logic [IW-1:0] exp_next;
  logic [S-1:0]  onehot_next;
  logic [3:0]    streak_inc;
  logic          legal;
  logic          is_step;
  logic          is_rep;
  logic          hold_ok;
  logic          loss;

  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_adj
      assign adj_diff[gi] = code_in[gi] ^ code_in[gi+1];
    end
    for (gi = 0; gi < S; gi++) begin : g_onehot
      assign onehot_next[gi] = (idx == IW'(gi));
    end
  endgenerate

  always_comb begin
    diff_cnt = '0;
    ones_cnt = '0;
    for (int i = 0; i < N - 1; i++) diff_cnt = diff_cnt + (IW+1)'(adj_diff[i]);
    for (int i = 0; i < N; i++) ones_cnt = ones_cnt + (IW+1)'(code_in[i]);
    legal    = (diff_cnt <= (IW+1)'(1));
    // Upper half of the ring (msb set) counts down from 2N as ones drain out.
    idx_wide = code_in[N-1] ? (S_W - ones_cnt) : ones_cnt;
    idx      = idx_wide[IW-1:0];
    exp_next = (prev_reg == IW'(S - 1)) ? '0 : prev_reg + IW'(1);
    is_step  = legal && (idx == exp_next);
    is_rep   = legal && (idx == prev_reg);
    hold_ok  = is_step || (is_rep && HOLD);
    loss     = code_valid && (state_reg == LOCKED) && !hold_ok;
    streak_inc = streak_reg + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= UNLOCKED;
      streak_reg       <= '0;
      prev_reg         <= '0;
      index_reg        <= '0;
      onehot_reg       <= '0;
      index_valid_reg  <= 1'b0;
      illegal_code_reg <= 1'b0;
      seq_error_reg    <= 1'b0;
      locked_reg       <= 1'b0;
    end else begin
      index_valid_reg  <= 1'b0;
      illegal_code_reg <= 1'b0;
      seq_error_reg    <= 1'b0;
      onehot_reg       <= '0;
      if (code_valid) begin
        illegal_code_reg <= !legal;
        if (legal) begin
          index_reg       <= idx;
          onehot_reg      <= onehot_next;
          index_valid_reg <= 1'b1;
        end
        case (state_reg)
          UNLOCKED: begin
            if (!legal) begin
              streak_reg <= '0;
            end else if (streak_reg == '0 || !(is_step || is_rep)) begin
              prev_reg   <= idx;
              streak_reg <= 4'd1;
              if (LC == 4'd1) begin
                state_reg  <= LOCKED;
                locked_reg <= 1'b1;
              end
            end else if (is_step) begin
              prev_reg   <= idx;
              streak_reg <= streak_inc;
              if (streak_inc == LC) begin
                state_reg  <= LOCKED;
                locked_reg <= 1'b1;
              end
            end else if (!HOLD) begin
              streak_reg <= 4'd1;
              if (LC == 4'd1) begin
                state_reg  <= LOCKED;
                locked_reg <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (hold_ok) begin
              prev_reg <= idx;
            end else begin
              seq_error_reg <= 1'b1;
              locked_reg    <= 1'b0;
              state_reg     <= UNLOCKED;
              // A legal but wrong sample becomes the seed of the next lock attempt.
              if (legal) begin
                prev_reg   <= idx;
                streak_reg <= 4'd1;
              end else begin
                streak_reg <= '0;
              end
            end
          end
          default: state_reg <= UNLOCKED;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_reg <= '0;
    end else if (err_clr) begin
      err_count_reg <= '0;
    end else if (loss && err_count_reg != 8'hFF) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end

  assign index_out    = index_reg;
  assign onehot_out   = onehot_reg;
  assign index_valid  = index_valid_reg;
  assign illegal_code = illegal_code_reg;
  assign seq_error    = seq_error_reg;
  assign locked       = locked_reg;
  assign err_count    = err_count_reg;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder: one instance with hold allowed, one without,
// sharing the same stimulus stream.
module tb_johnson_decoder;

  logic       clk;
  logic       reset;
  logic [3:0] code_in;
  logic       code_valid;
  logic       err_clr;

  logic [2:0] a_index, b_index;
  logic [7:0] a_onehot, b_onehot;
  logic       a_valid, b_valid, a_illegal, b_illegal, a_seqerr, b_seqerr, a_locked, b_locked;
  logic [7:0] a_err, b_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  johnson_decoder #(.N(4), .LOCK_COUNT(4), .ALLOW_HOLD(1)) u_hold (
    .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid), .err_clr(err_clr),
    .index_out(a_index), .onehot_out(a_onehot), .index_valid(a_valid), .illegal_code(a_illegal),
    .seq_error(a_seqerr), .locked(a_locked), .err_count(a_err)
  );

  johnson_decoder #(.N(4), .LOCK_COUNT(4), .ALLOW_HOLD(0)) u_nohold (
    .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid), .err_clr(err_clr),
    .index_out(b_index), .onehot_out(b_onehot), .index_valid(b_valid), .illegal_code(b_illegal),
    .seq_error(b_seqerr), .locked(b_locked), .err_count(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input logic [3:0] c, input logic v);
    code_in    = c;
    code_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] seq_codes [9];
    logic [7:0] oh;
    seq_codes = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

    reset = 1'b1; code_in = '0; code_valid = 1'b0; err_clr = 1'b0;
    #1;
    chk("rst_index", a_index, 0);
    chk("rst_onehot", a_onehot, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_locked", a_locked, 0);
    chk("rst_err", a_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Lock and wrap
    for (int k = 0; k < 9; k++) begin
      drive(seq_codes[k], 1'b1);
      oh = 8'd1 << (k % 8);
      $display("lock/wrap sample %0d code %b -> index %0d locked %0d", k, seq_codes[k], a_index, a_locked);
      chk("wrap_index", a_index, k % 8);
      chk("wrap_valid", a_valid, 1);
      chk("wrap_onehot", a_onehot, oh);
      chk("wrap_locked", a_locked, (k >= 3) ? 1 : 0);
      chk("wrap_seqerr", a_seqerr, 0);
      chk("wrap_b_locked", b_locked, (k >= 3) ? 1 : 0);
    end
    chk("wrap_err", a_err, 0);

    // Illegal code while locked
    drive(4'b0101, 1'b1);
    $display("illegal 0101 -> illegal %0d seq_error %0d err %0d", a_illegal, a_seqerr, a_err);
    chk("ill_flag", a_illegal, 1);
    chk("ill_seqerr", a_seqerr, 1);
    chk("ill_locked", a_locked, 0);
    chk("ill_err", a_err, 1);
    chk("ill_index", a_index, 0);
    chk("ill_valid", a_valid, 0);
    chk("ill_onehot", a_onehot, 0);
    chk("ill_b_err", b_err, 1);

    // Skip step: lock at index 2, then jump to 4
    drive(4'b1000, 1'b1);
    drive(4'b0000, 1'b1);
    drive(4'b0001, 1'b1);
    chk("skip_prelock", a_locked, 0);
    drive(4'b0011, 1'b1);
    chk("skip_lock2", a_locked, 1);
    drive(4'b1111, 1'b1);
    $display("skip 1111 -> index %0d seq_error %0d locked %0d", a_index, a_seqerr, a_locked);
    chk("skip_seqerr", a_seqerr, 1);
    chk("skip_locked", a_locked, 0);
    chk("skip_index", a_index, 4);
    chk("skip_err", a_err, 2);
    drive(4'b1110, 1'b1);
    chk("skip_s2_locked", a_locked, 0);
    drive(4'b1100, 1'b1);
    chk("skip_s3_locked", a_locked, 0);
    drive(4'b1000, 1'b1);
    $display("relock 1000 -> index %0d locked %0d", a_index, a_locked);
    chk("relock", a_locked, 1);
    chk("relock_seqerr", a_seqerr, 0);
    chk("relock_b", b_locked, 1);

    // Hold and gaps
    drive(4'b0000, 1'b1);
    drive(4'b0001, 1'b1);
    drive(4'b0011, 1'b1);
    drive(4'b0000, 1'b0);
    chk("gap_valid", a_valid, 0);
    chk("gap_onehot", a_onehot, 0);
    chk("gap_locked", a_locked, 1);
    drive(4'b0011, 1'b1);
    $display("hold#1 0011 -> a locked %0d b seq_error %0d b locked %0d", a_locked, b_seqerr, b_locked);
    chk("hold1_valid", a_valid, 1);
    chk("hold1_seqerr", a_seqerr, 0);
    chk("hold1_locked", a_locked, 1);
    chk("hold1_b_seqerr", b_seqerr, 1);
    chk("hold1_b_locked", b_locked, 0);
    chk("hold1_b_err", b_err, 3);
    drive(4'b0000, 1'b0);
    drive(4'b0011, 1'b1);
    chk("hold2_locked", a_locked, 1);
    chk("hold2_b_seqerr", b_seqerr, 0);
    drive(4'b0000, 1'b0);
    drive(4'b0011, 1'b1);
    chk("hold3_locked", a_locked, 1);
    chk("hold3_seqerr", a_seqerr, 0);
    chk("hold3_err", a_err, 2);
    drive(4'b0111, 1'b1);
    chk("hold_step_locked", a_locked, 1);
    chk("hold_step_index", a_index, 3);

    // Saturation: illegal loss then four-step relock, 300 times
    for (int i = 0; i < 300; i++) begin
      drive(4'b0101, 1'b1);
      drive(4'b0000, 1'b1);
      drive(4'b0001, 1'b1);
      drive(4'b0011, 1'b1);
      drive(4'b0111, 1'b1);
      if (i == 9) begin
        $display("saturation after 10 losses -> err %0d", a_err);
        chk("sat_mid", a_err, 12);
        chk("sat_mid_b", b_err, 12);
      end
    end
    $display("saturation after 300 losses -> err %0d", a_err);
    chk("sat_err", a_err, 255);
    chk("sat_b_err", b_err, 255);
    chk("sat_locked", a_locked, 1);

    // err_clr coincident with a loss
    err_clr = 1'b1;
    drive(4'b0101, 1'b1);
    err_clr = 1'b0;
    $display("clear+loss -> err %0d seq_error %0d", a_err, a_seqerr);
    chk("clr_err", a_err, 0);
    chk("clr_seqerr", a_seqerr, 1);

    // Async reset while locked at index 5
    drive(4'b0011, 1'b1);
    drive(4'b0111, 1'b1);
    drive(4'b1111, 1'b1);
    drive(4'b1110, 1'b1);
    chk("pre_rst_locked", a_locked, 1);
    chk("pre_rst_index", a_index, 5);
    code_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    $display("async reset -> index %0d locked %0d onehot %0d", a_index, a_locked, a_onehot);
    chk("arst_index", a_index, 0);
    chk("arst_onehot", a_onehot, 0);
    chk("arst_locked", a_locked, 0);
    chk("arst_err", a_err, 0);
    chk("arst_illegal", a_illegal, 0);
    chk("arst_seqerr", a_seqerr, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    drive(4'b1100, 1'b1);
    $display("post-reset 1100 -> index %0d valid %0d locked %0d", a_index, a_valid, a_locked);
    chk("post_valid", a_valid, 1);
    chk("post_index", a_index, 6);
    chk("post_onehot", a_onehot, 64);
    chk("post_locked", a_locked, 0);
    code_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the Johnson counter. Samples an N-bit Johnson (twisted-ring) code and decodes it to a binary index and a one-hot vector. Checks that every sample is a legal Johnson code and that consecutive samples advance by exactly one step. Sits downstream of any Johnson-coded sequencer and reports lock status and error statistics to control logic.

## Interface
- N, default 4: Johnson code width; the sequence has 2N states; N ≥ 2.
- LOCK_COUNT, default 4: consecutive legal, correctly stepping samples required to declare lock; 1..15.
- ALLOW_HOLD, default 1: 1 = a repeated index is accepted without error; 0 = a repeat counts as a step error.
- clk, input, 1: rising-edge clock; the only clock.
- reset, input, 1: asynchronous, active-high reset.
- code_in, input, N: Johnson code sample.
- code_valid, input, 1: code_in is sampled on a clk edge where code_valid=1.
- err_clr, input, 1: synchronous clear of err_count.
- index_out, output, clog2(2N): decoded state index, registered.
- onehot_out, output, 2N: one-hot of index_out; all zeros when index_valid=0.
- index_valid, output, 1: 1-cycle pulse; index_out and onehot_out hold a new legal decode.
- illegal_code, output, 1: 1-cycle pulse; the sampled code is not a Johnson code.
- seq_error, output, 1: 1-cycle pulse; lock was lost on this sample.
- locked, output, 1: level; decoder is locked to the sequence.
- err_count, output, 8: number of lock-loss events; saturates at 255.

## Operation
- Sequence (N=4, index:code): 0:0000, 1:0001, 2:0011, 3:0111, 4:1111, 5:1110, 6:1100, 7:1000. Each step shifts left, and ~msb enters bit 0.
- Legality: a code is legal iff at most one adjacent-bit pair (i, i+1), i = 0..N-2, differs. This gives exactly 2N legal codes.
- Decode: p = popcount(code_in). If code_in[N-1]=0, index = p. Otherwise, index = 2N − p.
- Expected next index: (prev + 1) mod 2N. Index 2N−1 wraps to 0.
- State machine: UNLOCKED and LOCKED. It also holds a streak counter (4 bits) and prev (the last legal index).
- UNLOCKED behaviour:
  - Illegal sample: streak=0.
  - Legal sample with streak=0: prev=index, streak=1.
  - Legal sample equal to prev+1: streak+1, prev=index.
  - Legal repeat: no change if ALLOW_HOLD=1, else streak=1.
  - Other legal sample: streak=1, prev=index.
  - When streak reaches LOCK_COUNT, go to LOCKED.
- LOCKED behaviour:
  - Legal sample equal to prev+1, or a repeat with ALLOW_HOLD=1: update prev and stay LOCKED.
  - Illegal sample, bad step, or a repeat with ALLOW_HOLD=0: seq_error pulse, err_count+1 (saturating), go to UNLOCKED.
  - After a bad legal step, the new sample seeds prev with streak=1.
  - After an illegal sample, streak=0.
- illegal_code pulses for every illegal sample in either state.
- seq_error and err_count activity occur only on LOCKED-to-UNLOCKED exits.
- index_valid pulses for every legal sample in either state. index_out and onehot_out update on that sample; illegal samples leave index_out unchanged.
- err_clr clears err_count to 0. If err_clr coincides with an increment, err_clr wins.
- code_valid=0: no state, streak or prev change; all pulse outputs are 0.

## Timing
- All outputs are registered, with 1-cycle latency from the sampling edge (code_valid=1) to the outputs.
- locked rises in the same cycle as the index_valid of the LOCK_COUNT-th qualifying sample.
- locked falls in the same cycle as seq_error.
- Back-to-back samples are supported every cycle; there is no backpressure.
- Reset (asynchronous assert) clears everything immediately: index_out=0, onehot_out=0, index_valid=0, illegal_code=0, seq_error=0, locked=0, err_count=0, state=UNLOCKED, streak=0, prev=0.
- Reset mid-stream discards lock. The first valid sample after release is treated as a fresh seed.

## Test plan
- Lock and wrap (N=4, LOCK_COUNT=4): feed 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 with code_valid=1 every cycle. Required: index_out = 0,1,2,3,4,5,6,7,0 at 1-cycle latency; locked rises with the 4th sample (index 3); no errors across the 7→0 wrap.
- Illegal code while locked: after lock, inject 0101. Required: illegal_code=1, seq_error=1, locked=0, err_count=1, index_out unchanged.
- Skip step: locked at index 2, feed 1111 (index 4). Required: seq_error=1, locked=0, index_out=4. Then feed 1110, 1100, 1000. Required: relock on 1000 (streak 4).
- Hold and gaps: locked, repeat 0011 three times with ALLOW_HOLD=1, interleaved with code_valid=0 cycles. Required: no errors, locked stays 1. With ALLOW_HOLD=0, the first repeat gives seq_error=1.
- Saturation and clear: force 300 lock-loss events. Required: err_count=255. Assert err_clr in the same cycle as a loss. Required: err_count=0.
- Asynchronous reset mid-stream: while locked at index 5, assert reset between clock edges. Required: all outputs 0 immediately. After release, sample 1100 gives index_valid=1, index_out=6, locked=0.
